// File: rtl/inst_cache_param.sv
// Direct-mapped instruction cache with a combinational hit path and a
// word-per-beat line refill engine that can be squashed by a flush.
module inst_cache_param #(
    parameter int IDX_BITS  = 5,
    parameter int WORD_BITS = 1,
    parameter int ADDR_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    output logic        hit,
    output logic [31:0] ins_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int LINES   = 1 << IDX_BITS;
    localparam int WORDS   = 1 << WORD_BITS;
    localparam int IDX_LSB = WORD_BITS + 2;
    localparam int TAG_LSB = IDX_BITS + WORD_BITS + 2;
    localparam int TAG_W   = ADDR_BITS - TAG_LSB;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag_arr [LINES];
    logic [31:0]            r_data_arr [LINES*WORDS];

    // Line-aligned refill address, i.e. pc_addr[31:IDX_LSB] captured on the miss.
    logic [31-IDX_LSB:0]    r_base_line;
    logic [WORD_BITS-1:0]   r_beat;
    logic                   r_squash;
    logic                   r_mem_req;
    logic [31:0]            r_mem_addr;

    logic [WORD_BITS-1:0]   w_offset;
    logic [IDX_BITS-1:0]    w_index;
    logic [TAG_W-1:0]       w_tag;
    logic [IDX_BITS-1:0]    w_ref_index;
    logic [TAG_W-1:0]       w_ref_tag;
    logic [WORD_BITS-1:0]   w_beat_inc;
    logic                   w_start;
    logic                   w_ack;
    logic                   w_last;
    logic                   w_unused;

    assign w_offset    = pc_addr[IDX_LSB-1:2];
    assign w_index     = pc_addr[TAG_LSB-1:IDX_LSB];
    assign w_tag       = pc_addr[ADDR_BITS-1:TAG_LSB];
    assign w_ref_index = r_base_line[IDX_BITS-1:0];
    assign w_ref_tag   = r_base_line[ADDR_BITS-1-IDX_LSB:IDX_BITS];
    assign w_beat_inc  = r_beat + 1'b1;
    assign w_unused    = ^pc_addr[1:0];

    assign hit      = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);
    assign ins_out  = hit ? r_data_arr[{w_index, w_offset}] : 32'd0;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    // A flush in the same cycle as a miss wins: no refill is started.
    assign w_start = rdy && (r_state == S_IDLE) && !flush && !hit;
    assign w_ack   = rdy && (r_state == S_REFILL) && mem_ack;
    assign w_last  = w_ack && (&r_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_REFILL;
            S_REFILL: if (w_last)  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_base_line <= '0;
            r_beat      <= '0;
            r_squash    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
        end else if (rdy) begin
            if (w_start) begin
                r_base_line <= pc_addr[31:IDX_LSB];
                r_beat      <= '0;
                r_squash    <= 1'b0;
                r_mem_req   <= 1'b1;
                r_mem_addr  <= {pc_addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
            end
            if (w_ack) begin
                r_beat     <= w_beat_inc;
                r_mem_addr <= {r_base_line, w_beat_inc, 2'b00};
                if (w_last) begin
                    r_mem_req <= 1'b0;
                end
            end
            if (flush && (r_state == S_REFILL)) begin
                r_squash <= 1'b1;
            end
            // Line being refilled stays invalid until its last beat lands.
            if (flush) begin
                r_valid <= '0;
            end else begin
                if (w_start) begin
                    r_valid[w_index] <= 1'b0;
                end
                if (w_last && !r_squash) begin
                    r_valid[w_ref_index] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_ack) begin
            r_data_arr[{w_ref_index, r_beat}] <= mem_data;
        end
        if (!rst && w_last) begin
            r_tag_arr[w_ref_index] <= w_ref_tag;
        end
    end

endmodule
